// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, debug single-step
// and HALT drain sequencing, plus a saturating count of PC-frozen cycles.
module hazard_controller #(
  parameter int SIZE_REG_DIR = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIZE_REG_DIR-1:0] i_rs_id,
  input  logic [SIZE_REG_DIR-1:0] i_rt_id,
  input  logic                    i_uses_rt,
  input  logic [SIZE_REG_DIR-1:0] i_rt_id_ex,
  input  logic                    i_mem_read_id_ex,
  input  logic                    i_branch_taken,
  input  logic                    i_halt,
  input  logic                    i_step_mode,
  input  logic                    i_step,
  output logic                    o_pc_write,
  output logic                    o_if_id_write,
  output logic                    o_if_id_flush,
  output logic                    o_id_ex_bubble,
  output logic                    o_halted,
  output logic [2:0]              o_state,
  output logic [CNT_W-1:0]        o_stall_count
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    STEP_IDLE = 3'd1,
    STEP_ADV  = 3'd2,
    DRAIN     = 3'd3,
    HALTED    = 3'd4
  } state_t;

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [DCW-1:0]   drain_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = i_mem_read_id_ex && (i_rt_id_ex != '0) &&
                    ((i_rt_id_ex == i_rs_id) || (i_uses_rt && (i_rt_id_ex == i_rt_id)));

  always_comb begin
    state_nxt    = state;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state)
      RUN, STEP_ADV: begin
        // A HALT sitting in ID is held there (stall) while the pipe drains.
        if (i_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use || (state == RUN && i_halt)) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        if (i_halt && !i_branch_taken)
          state_nxt = DRAIN;
        else if (state == STEP_ADV)
          state_nxt = STEP_IDLE;
        else if (i_step_mode)
          state_nxt = STEP_IDLE;
      end
      STEP_IDLE: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if (i_step)
          state_nxt = STEP_ADV;
        else if (!i_step_mode)
          state_nxt = RUN;
      end
      DRAIN: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        if (drain_cnt == DRAIN_LAST)
          state_nxt = HALTED;
      end
      HALTED: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    // Hold the pipeline in plain run behaviour while reset is asserted.
    if (!rst) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
      if (!pc_write)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign o_pc_write     = pc_write;
  assign o_if_id_write  = if_id_write;
  assign o_if_id_flush  = if_id_flush;
  assign o_id_ex_bubble = id_ex_bubble;
  assign o_halted       = (state == HALTED);
  assign o_state        = state;
  assign o_stall_count  = stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: vector table, directed corner sequences and
// randomized traffic checked against a rule-level reference model.
module tb_hazard_controller;

  localparam int CW = 4;
  localparam int DC = 3;
  localparam int M_RUN = 0, M_IDLE = 1, M_ADV = 2, M_DRAIN = 3, M_HALTED = 4;
  localparam int STALL_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [4:0]    rs_id, rt_id, rt_id_ex;
  logic          uses_rt, mem_read, branch_taken, halt, step_mode, step;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, halted;
  logic [2:0]    state;
  logic [CW-1:0] stall_count;

  hazard_controller #(.SIZE_REG_DIR(5), .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_rs_id(rs_id), .i_rt_id(rt_id), .i_uses_rt(uses_rt),
    .i_rt_id_ex(rt_id_ex), .i_mem_read_id_ex(mem_read),
    .i_branch_taken(branch_taken), .i_halt(halt),
    .i_step_mode(step_mode), .i_step(step),
    .o_pc_write(pc_write), .o_if_id_write(if_id_write),
    .o_if_id_flush(if_id_flush), .o_id_ex_bubble(id_ex_bubble),
    .o_halted(halted), .o_state(state), .o_stall_count(stall_count)
  );

  typedef struct {
    logic [4:0] rs, rt, rtex;
    logic       ut, mr, br, halt, sm, step;
  } in_t;

  typedef struct {
    in_t        i;
    logic [3:0] exp;  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int m_state, m_drain, m_stall;
  logic [3:0] last_outs;
  int last_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input int rs_v, input int rt_v, input int ut_v, input int rtex_v,
                             input int mr_v, input int br_v, input int halt_v,
                             input int sm_v, input int step_v);
    in_t r;
    r.rs = 5'(rs_v); r.rt = 5'(rt_v); r.ut = ut_v[0]; r.rtex = 5'(rtex_v);
    r.mr = mr_v[0]; r.br = br_v[0]; r.halt = halt_v[0];
    r.sm = sm_v[0]; r.step = step_v[0];
    return r;
  endfunction

  // Outputs follow from which kind of cycle the pipeline is having.
  function automatic logic [3:0] model_out(input in_t v);
    bit hazard;
    bit advancing;
    hazard = v.mr && (v.rtex != 0) && (v.rtex == v.rs || (v.ut && v.rtex == v.rt));
    advancing = (m_state == M_RUN) || (m_state == M_ADV);
    if (m_state == M_IDLE) return 4'b0000;
    if (!advancing)        return 4'b0001;
    if (v.br)              return 4'b1111;
    if (hazard)            return 4'b0001;
    if (m_state == M_RUN && v.halt) return 4'b0001;
    return 4'b1100;
  endfunction

  task automatic model_step(input in_t v, input logic pc_w);
    if (!pc_w && m_stall < STALL_MAX) m_stall++;
    if (m_state == M_DRAIN) begin
      m_drain++;
      if (m_drain == DC) m_state = M_HALTED;
    end else if ((m_state == M_RUN || m_state == M_ADV) && v.halt && !v.br) begin
      m_state = M_DRAIN;
      m_drain = 0;
    end else if (m_state == M_ADV) begin
      m_state = M_IDLE;
    end else if (m_state == M_RUN) begin
      if (v.sm) m_state = M_IDLE;
    end else if (m_state == M_IDLE) begin
      if (v.step) m_state = M_ADV;
      else if (!v.sm) m_state = M_RUN;
    end
  endtask

  task automatic drive(input in_t v);
    rs_id = v.rs; rt_id = v.rt; uses_rt = v.ut; rt_id_ex = v.rtex;
    mem_read = v.mr; branch_taken = v.br; halt = v.halt;
    step_mode = v.sm; step = v.step;
  endtask

  task automatic cycle(input in_t v);
    logic [3:0] e;
    @(negedge clk);
    drive(v);
    #1;
    e = model_out(v);
    last_outs  = {pc_write, if_id_write, if_id_flush, id_ex_bubble};
    last_state = int'(state);
    check("outs", int'(last_outs), int'(e));
    check("state", int'(state), m_state);
    check("halted", int'(halted), int'(m_state == M_HALTED));
    check("stall_count", int'(stall_count), m_stall);
    @(posedge clk);
    model_step(v, e[3]);
  endtask

  // Asserts reset at the current time, with hazard-provoking inputs applied.
  task automatic do_reset();
    drive(mk(5, 5, 1, 5, 1, 1, 1, 1, 1));
    rst = 1'b0;
    #1;
    check("rst_outs", int'({pc_write, if_id_write, if_id_flush, id_ex_bubble}), 4'b1100);
    check("rst_state", int'(state), M_RUN);
    check("rst_stall", int'(stall_count), 0);
    check("rst_halted", int'(halted), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    m_state = M_RUN; m_drain = 0; m_stall = 0;
  endtask

  vec_t tbl[8];
  in_t  idle;
  int   adv_seen;
  int   exp_st[6];
  bit   sm_hold;

  initial begin
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{mk(5, 0, 0, 5, 1, 0, 0, 0, 0), 4'b0001};  // rs load-use
    tbl[1] = '{mk(0, 0, 1, 0, 1, 0, 0, 0, 0), 4'b1100};  // r0 never hazards
    tbl[2] = '{mk(3, 7, 0, 7, 1, 0, 0, 0, 0), 4'b1100};  // rt match, rt unused
    tbl[3] = '{mk(3, 7, 1, 7, 1, 0, 0, 0, 0), 4'b0001};  // rt match, rt used
    tbl[4] = '{mk(5, 0, 0, 5, 0, 0, 0, 0, 0), 4'b1100};  // not a load
    tbl[5] = '{mk(5, 0, 0, 5, 1, 1, 0, 0, 0), 4'b1111};  // branch beats load-use
    tbl[6] = '{mk(1, 2, 1, 9, 0, 1, 0, 0, 0), 4'b1111};  // plain branch
    tbl[7] = '{mk(9, 4, 1, 5, 1, 0, 0, 0, 0), 4'b1100};  // load, no match
    exp_st = '{M_DRAIN, M_DRAIN, M_DRAIN, M_HALTED, M_HALTED, M_HALTED};
    #2;
    do_reset();

    foreach (tbl[k]) begin
      cycle(tbl[k].i);
      check($sformatf("tbl%0d", k), int'(last_outs), int'(tbl[k].exp));
    end

    // Single load-use stall then normal flow.
    do_reset();
    cycle(mk(5, 0, 0, 5, 1, 0, 0, 0, 0));
    check("lu_stall", int'(last_outs), 4'b0001);
    cycle(idle);
    check("lu_after", int'(last_outs), 4'b1100);
    #1 check("lu_count", int'(stall_count), 1);

    // Branch alongside load-use does not count as a stall.
    do_reset();
    cycle(mk(5, 0, 0, 5, 1, 1, 0, 0, 0));
    check("br_lu", int'(last_outs), 4'b1111);
    #1 check("br_count", int'(stall_count), 0);

    // HALT: three drain cycles, then halted for good despite activity.
    do_reset();
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 6; k++) begin
      #1;
      check("halt_state", int'(state), exp_st[k]);
      check("halt_flag", int'(halted), int'(k >= 3));
      cycle(mk(5, 0, 0, 5, 1, k % 2, 0, 1, 1));
    end

    // Reset in the middle of draining returns to RUN at once.
    do_reset();
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    cycle(idle);
    do_reset();

    // Three single steps, five cycles apart.
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    adv_seen = 0;
    for (int p = 0; p < 3; p++) begin
      cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
      if (last_state == M_ADV) adv_seen++;
      for (int q = 0; q < 4; q++) begin
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        if (last_state == M_ADV) adv_seen++;
      end
    end
    check("step_adv_cycles", adv_seen, 3);
    #1 check("step_frozen", int'(stall_count), 12);

    // Stall counter saturates.
    do_reset();
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < (1 << CW) + 5; k++) cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    #1 check("stall_sat", int'(stall_count), STALL_MAX);

    // Randomized traffic against the reference model.
    do_reset();
    sm_hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) sm_hold = !sm_hold;
      cycle(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1),
               int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 39) == 0),
               int'(sm_hold), int'($urandom_range(0, 3) == 0)));
      if (m_state == M_HALTED && $urandom_range(0, 7) == 0) do_reset();
      else if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
